// File: rtl/beam_trig_scaler_if.sv
// beam_trig_scaler_if
//   Latched scaler stream between beam_trig_scaler and its consumer.
//   Parameter CNT_WIDTH must match the scaler instance.
//
//   scal_o        latched counts, beam 0 in the low half, beam 1 in the high half
//   scal_valid_o  latched counts available, held until accepted
//   scal_ready_i  consumer accepts scal_o while scal_valid_o is high
//   overrun_o     sticky flag: unread counts were overwritten
//
//   master = scaler side, slave = consumer side.

interface beam_trig_scaler_if #(
    parameter int CNT_WIDTH = 16
);
    logic [2*CNT_WIDTH-1:0] scal_o;
    logic                   scal_valid_o;
    logic                   scal_ready_i;
    logic                   overrun_o;

    modport master (
        output scal_o,
        output scal_valid_o,
        output overrun_o,
        input  scal_ready_i
    );

    modport slave (
        input  scal_o,
        input  scal_valid_o,
        input  overrun_o,
        output scal_ready_i
    );
endinterface

// File: rtl/beam_trig_scaler.sv
// beam_trig_scaler
//   Per-beam trigger edge qualification with holdoff, plus a gated scaler
//   that counts accepted triggers over a programmable gate and latches the
//   counts to a valid/ready output.
//
//   clk_i      sole clock, rising edge
//   rst_i      synchronous, active-high reset
//   trigger_i  raw per-beam triggers (bit n = beam n)
//   enable_i   high = scaler running
//   holdoff_i  dead-time in clocks after each accepted trigger
//   period_i   gate length minus 1, in clocks
//   trig_o     holdoff-qualified one-clock trigger pulses
//   scal_if    latched count stream (master side)
//
//   Build option: define SCALER_OVERRUN_EN to build the sticky overrun flag;
//   otherwise overrun_o is tied low.
//
//   state | meaning
//   IDLE  | scaler stopped, running counts and gate position held at 0
//   RUN   | gate running, accepted triggers counted, latch on terminal cycle

module beam_trig_scaler #(
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              trigger_i,
    input  logic                    enable_i,
    input  logic [7:0]              holdoff_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic [1:0]              trig_o,
    beam_trig_scaler_if.master      scal_if
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   run_active;
    logic   gate_start;
    logic   gate_stop;

    logic [1:0]              trig_prev;
    logic [7:0]              holdoff_cnt [2];
    logic [1:0]              accept;
    logic [CNT_WIDTH-1:0]    run_cnt     [2];
    logic [CNT_WIDTH-1:0]    run_inc     [2];
    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic [PERIOD_WIDTH-1:0] period_reg;
    logic                    terminal;
    logic [2*CNT_WIDTH-1:0]  scal_q;
    logic                    scal_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        run_active = 1'b0;
        gate_start = 1'b0;
        gate_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_nxt  = RUN;
                    gate_start = 1'b1;
                end
            end
            RUN: begin
                run_active = 1'b1;
                if (!enable_i) begin
                    state_nxt = IDLE;
                    gate_stop = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Rising edge with the holdoff window expired.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            accept[n] = trigger_i[n] & ~trig_prev[n] & (holdoff_cnt[n] == 8'd0);
        end
    end

    // History resets to 1 so a trigger held high through reset is not an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_prev <= 2'b11;
            trig_o    <= 2'b00;
            for (int n = 0; n < 2; n++) holdoff_cnt[n] <= 8'd0;
        end else begin
            trig_prev <= trigger_i;
            trig_o    <= accept;
            for (int n = 0; n < 2; n++) begin
                if (accept[n])                  holdoff_cnt[n] <= holdoff_i;
                else if (holdoff_cnt[n] != 8'd0) holdoff_cnt[n] <= holdoff_cnt[n] - 8'd1;
            end
        end
    end

    // Saturating count including this cycle's trigger, so a trigger in the
    // terminal cycle still lands in the latched value.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            if (run_active && accept[n] && (run_cnt[n] != {CNT_WIDTH{1'b1}}))
                run_inc[n] = run_cnt[n] + CNT_WIDTH'(1);
            else
                run_inc[n] = run_cnt[n];
        end
    end

    assign terminal = run_active && (period_cnt == period_reg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt <= '0;
            period_reg <= '0;
            scal_q     <= '0;
            for (int n = 0; n < 2; n++) run_cnt[n] <= '0;
        end else if (!run_active) begin
            period_cnt <= '0;
            for (int n = 0; n < 2; n++) run_cnt[n] <= '0;
            if (gate_start) period_reg <= period_i;
        end else if (terminal) begin
            period_cnt <= '0;
            period_reg <= period_i;
            scal_q     <= {run_inc[1], run_inc[0]};
            for (int n = 0; n < 2; n++) run_cnt[n] <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_WIDTH'(1);
            for (int n = 0; n < 2; n++) run_cnt[n] <= run_inc[n];
        end
    end

    // A latch on the accepting edge keeps valid high.
    always_ff @(posedge clk_i) begin
        if (rst_i)                     scal_valid_q <= 1'b0;
        else if (terminal)             scal_valid_q <= 1'b1;
        else if (scal_if.scal_ready_i) scal_valid_q <= 1'b0;
    end

    assign scal_if.scal_o       = scal_q;
    assign scal_if.scal_valid_o = scal_valid_q;

`ifdef SCALER_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            overrun_q <= 1'b0;
        else if (gate_stop)
            overrun_q <= 1'b0;
        else if (terminal && scal_valid_q && !scal_if.scal_ready_i)
            overrun_q <= 1'b1;
    end

    assign scal_if.overrun_o = overrun_q;
`else
    assign scal_if.overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_beam_trig_scaler.sv
module tb_beam_trig_scaler;

`ifdef SCALER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  trigger;
    logic        enable;
    logic [7:0]  holdoff;
    logic [23:0] period;
    logic        ready;
    logic [1:0]  trig16;
    logic [1:0]  trig4;

    int checks   = 0;
    int failures = 0;

    beam_trig_scaler_if #(.CNT_WIDTH(16)) if16 ();
    beam_trig_scaler_if #(.CNT_WIDTH(4))  if4 ();

    assign if16.scal_ready_i = ready;
    assign if4.scal_ready_i  = ready;

    beam_trig_scaler #(.CNT_WIDTH(16), .PERIOD_WIDTH(24)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .trigger_i (trigger),
        .enable_i  (enable),
        .holdoff_i (holdoff),
        .period_i  (period),
        .trig_o    (trig16),
        .scal_if   (if16.master)
    );

    beam_trig_scaler #(.CNT_WIDTH(4), .PERIOD_WIDTH(24)) dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .trigger_i (trigger),
        .enable_i  (enable),
        .holdoff_i (holdoff),
        .period_i  (period),
        .trig_o    (trig4),
        .scal_if   (if4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        trigger = 2'b11;
        enable  = 1'b0;
        holdoff = 8'd0;
        period  = 24'd0;
        ready   = 1'b0;

        // Reset with triggers held high.
        repeat (3) step();
        chk("rst_trig", 64'(trig16), 64'd0);
        chk("rst_scal", 64'(if16.scal_o), 64'd0);
        chk("rst_valid", 64'(if16.scal_valid_o), 64'd0);
        chk("rst_overrun", 64'(if16.overrun_o), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_high_no_pulse", 64'(trig16), 64'd0);
        end
        trigger = 2'b00;
        step();
        chk("fall_no_pulse", 64'(trig16), 64'd0);
        trigger = 2'b11;
        step();
        chk("rise_pulse", 64'(trig16), 64'd3);
        step();
        chk("pulse_one_clock", 64'(trig16), 64'd0);

        // Holdoff 4 with beam 0 toggling every clock: pulses every 6 clocks.
        holdoff = 8'd4;
        trigger = 2'b00;
        step();
        for (int i = 0; i < 20; i++) begin
            trigger = {1'b0, (i % 2 == 0)};
            step();
            chk("holdoff_pulse", 64'(trig16), 64'((i % 6) == 0));
        end
        trigger = 2'b00;
        holdoff = 8'd0;
        repeat (5) step();

        // Gate count: 100-clock gate, beam0 every 10, beam1 every 25.
        ready  = 1'b1;
        period = 24'd99;
        enable = 1'b1;
        step();
        for (int c = 0; c < 350; c++) begin
            trigger = {(c % 25 == 0), (c % 10 == 0)};
            step();
            chk("gate_valid", 64'(if16.scal_valid_o), 64'((c % 100) == 99));
            if (c % 100 == 99) begin
                chk("gate_scal16", 64'(if16.scal_o), {32'd0, 16'd4, 16'd10});
                chk("gate_scal4", 64'(if4.scal_o), {56'd0, 4'd4, 4'd10});
            end
        end
        trigger = 2'b00;
        enable  = 1'b0;
        step();
        chk("disable_valid", 64'(if16.scal_valid_o), 64'd0);

        // Edge in the terminal cycle is counted; next gate starts from 0.
        period = 24'd9;
        enable = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            trigger = {1'b0, (c == 3 || c == 9 || c == 12)};
            step();
            if (c == 9)  chk("term_edge_scal", 64'(if16.scal_o), {32'd0, 16'd0, 16'd2});
            if (c == 19) chk("next_gate_scal", 64'(if16.scal_o), {32'd0, 16'd0, 16'd1});
        end
        trigger = 2'b00;
        enable  = 1'b0;
        step();

        // Saturation: 20 beam0 edges in one 50-clock gate.
        period = 24'd49;
        enable = 1'b1;
        step();
        for (int c = 0; c < 50; c++) begin
            trigger = {1'b0, (c < 40) && (c % 2 == 0)};
            step();
        end
        chk("sat_valid", 64'(if4.scal_valid_o), 64'd1);
        chk("sat_scal4", 64'(if4.scal_o), 64'h0f);
        chk("sat_scal16", 64'(if16.scal_o), {32'd0, 16'd0, 16'd20});
        trigger = 2'b00;
        enable  = 1'b0;
        step();

        // Overrun: two latches without ready.
        ready  = 1'b0;
        period = 24'd9;
        enable = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            trigger = {(c == 4 || c == 6), (c == 2 || c == 12 || c == 14 || c == 16)};
            step();
            if (c == 9) begin
                chk("ovr_first_scal", 64'(if16.scal_o), {32'd0, 16'd2, 16'd1});
                chk("ovr_first_valid", 64'(if16.scal_valid_o), 64'd1);
                chk("ovr_first_flag", 64'(if16.overrun_o), 64'd0);
            end
            if (c == 15) begin
                chk("ovr_stable_scal", 64'(if16.scal_o), {32'd0, 16'd2, 16'd1});
                chk("ovr_stable_valid", 64'(if16.scal_valid_o), 64'd1);
            end
            if (c == 19) begin
                chk("ovr_second_scal", 64'(if16.scal_o), {32'd0, 16'd0, 16'd3});
                chk("ovr_second_valid", 64'(if16.scal_valid_o), 64'd1);
                chk("ovr_flag", 64'(if16.overrun_o), 64'(OVR_EXP));
            end
        end
        trigger = 2'b00;
        ready   = 1'b1;
        step();
        chk("ovr_accept_valid", 64'(if16.scal_valid_o), 64'd0);
        chk("ovr_sticky", 64'(if16.overrun_o), 64'(OVR_EXP));
        enable = 1'b0;
        step();
        chk("ovr_cleared", 64'(if16.overrun_o), 64'd0);

        // period 0: latch every cycle, ready high keeps valid without overrun.
        period = 24'd0;
        enable = 1'b1;
        step();
        for (int c = 0; c < 6; c++) begin
            trigger = {(c == 2), 1'b0};
            step();
            chk("p0_valid", 64'(if16.scal_valid_o), 64'd1);
            chk("p0_overrun", 64'(if16.overrun_o), 64'd0);
            if (c == 2) chk("p0_scal_edge", 64'(if16.scal_o), {32'd0, 16'd1, 16'd0});
            if (c == 3) chk("p0_scal_next", 64'(if16.scal_o), 64'd0);
        end
        trigger = 2'b00;
        enable  = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beam_trig_scaler.md
BEAM_TRIG_SCALER -- requirements
Module: beam_trig_scaler

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of each per-beam scaler count.
REQ-002 Parameter PERIOD_WIDTH, default 24: width of the gate-period setting.
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset, as listed below.
REQ-004 clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 trigger_i  in  2  raw per-beam triggers from dual_pueo_beam_dsp trigger_o; bit n = beam n.
REQ-007 enable_i  in  1  high = scaler running; low = scaler idle.
REQ-008 holdoff_i  in  8  dead-time in clocks after each accepted trigger.
REQ-009 period_i  in  PERIOD_WIDTH  gate length minus 1, in clocks.
REQ-010 trig_o  out  2  holdoff-qualified, one-clock trigger pulses per beam.
REQ-011 scal_o  out  2*CNT_WIDTH  latched counts; [CNT_WIDTH-1:0] = beam 0, upper half = beam 1.
REQ-012 scal_valid_o  out  1  latched counts available; held until accepted.
REQ-013 scal_ready_i  in  1  consumer accepts scal_o when high with scal_valid_o.
REQ-014 overrun_o  out  1  sticky flag: unread counts were overwritten.

Function
REQ-015 An accepted trigger on beam n SHALL require three conditions in the same cycle: trigger_i[n]=1, the previous-cycle sample of trigger_i[n]=0, and holdoff counter n = 0.
REQ-016 trig_o[n] SHALL pulse high for exactly one clock, one cycle after the accepted edge; this is independent of enable_i.
REQ-017 On acceptance, holdoff counter n SHALL load holdoff_i and then decrement by 1 per clock to 0.
- holdoff_i=0 gives edge-only gating; the next edge can be accepted 2 cycles later.
REQ-018 The FSM SHALL have two states, IDLE and RUN.
- IDLE -> RUN when enable_i=1.
- RUN -> IDLE when enable_i=0.
- Entering IDLE clears the running counts and the period counter, and discards the partial gate (nothing is latched).
REQ-019 In RUN, the period counter SHALL count 0..period_i.
- Terminal cycle = count equals period_i; the counter then wraps to 0.
- period_i is sampled at RUN entry and at each terminal cycle; mid-gate changes take effect at the next gate.
REQ-020 Each running count SHALL increment on each accepted trigger in RUN and saturate at 2^CNT_WIDTH-1; it never wraps.
REQ-021 On the terminal cycle:
- running counts, including any trigger accepted in that same cycle, SHALL transfer to scal_o on the next edge;
- running counts SHALL restart at 0;
- scal_valid_o SHALL set.
REQ-022 scal_valid_o SHALL clear on the edge where scal_valid_o=1 and scal_ready_i=1, unless a new latch occurs on that same edge; in that case it stays 1 and no overrun is flagged.
REQ-023 A latch while scal_valid_o=1 and scal_ready_i=0 SHALL overwrite scal_o with the newer counts.
REQ-024 period_i=0 SHALL give a 1-clock gate, with a latch every cycle.
REQ-025 scal_o SHALL be stable whenever scal_valid_o=1 and no new latch occurs.

Reset
REQ-026 While rst_i=1 at a clock edge, the following SHALL be forced on that edge:
- FSM to IDLE;
- trig_o=0, scal_o=0, scal_valid_o=0, overrun_o=0;
- holdoff, period and running counters to 0;
- edge-detect history to 1, so a trigger held high through reset is not accepted.
REQ-027 Reset asserted mid-gate SHALL discard the partial counts; the first gate after reset starts on the first RUN cycle.

Configuration
REQ-028 Macro SCALER_OVERRUN_EN, when defined: overrun_o SHALL set on the latch edge of REQ-023 and clear only on rst_i or on the RUN -> IDLE transition.
REQ-029 Macro SCALER_OVERRUN_EN, when undefined: overrun_o SHALL be tied to 0 and no overrun logic is built.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset: rst_i=1 for 3 clocks with trigger_i=2'b11 held -> all outputs 0; no trig_o pulse after release until trigger_i falls and rises again.
- Holdoff: holdoff_i=4, trigger_i[0] toggles every clock for 20 clocks -> trig_o[0] pulses every 6 clocks, 4 pulses total.
- Gate count: enable_i=1, period_i=99, beam0 edge every 10 clocks, beam1 every 25, ready=1 -> scal_valid_o every 100 clocks with scal_o = {16'd4, 16'd10}.
- Terminal-cycle edge: a beam0 edge in the terminal cycle -> counted in the current latch; the next gate starts at 0.
- Saturation: CNT_WIDTH=4, 20 beam0 edges in one gate -> latched count 15.
- Overrun: ready=0 across two terminal cycles -> second counts replace the first, scal_valid_o stays 1, overrun_o=1 with the macro and 0 without; enable_i low clears overrun_o.
